// File: rtl/scr_trig_pkg.sv
// rtl/scr_trig_pkg.sv - shared encodings for the SCR gate-pulse trigger generator
package scr_trig_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PULSE_HI = 3'd1;
    localparam logic [2:0] ST_PULSE_LO = 3'd2;
    localparam logic [2:0] ST_DEAD     = 3'd3;
    localparam logic [2:0] ST_FAULT    = 3'd4;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/scr_pulse_timer.sv
// rtl/scr_pulse_timer.sv - loadable down-counter with a one-cycle expire strobe
module scr_pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;

    // A load of L makes expire fire on the L-th edge after the loading edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expire = (count_q == CNT_W'(1));

endmodule

// File: rtl/scr_trigger_gen.sv
// rtl/scr_trigger_gen.sv - bounded gate-pulse trains for the anti-parallel SCR pair
module scr_trigger_gen
    import scr_trig_pkg::*;
#(
    parameter int PULSE_WIDTH = 4,
    parameter int PULSE_GAP   = 2,
    parameter int PULSE_COUNT = 3,
    parameter int DEADTIME    = 8,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic i_clk_50m,
    input  logic i_rst,
    input  logic i_fire_forward,
    input  logic i_fire_negative,
    input  logic i_signal_forbid,
    input  logic i_forward_BOD,
    input  logic i_negative_BOD,
    input  logic i_fault_clr,
    output logic o_signal_forward,
    output logic o_signal_negative,
    output logic o_busy,
    output logic o_fire_ack,
    output logic o_fire_reject,
    output logic o_fault
);

    logic [2:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_expire;
    logic             accept;
    logic             fire_any, fire_one, bod_any;
    logic             sig_fwd_d, sig_neg_d, fault_d, ack_d, rej_d;
    logic             sig_fwd_q, sig_neg_q, fault_q, ack_q, rej_q;

    assign fire_any = i_fire_forward | i_fire_negative;
    assign fire_one = i_fire_forward ^ i_fire_negative;
    assign bod_any  = i_forward_BOD | i_negative_BOD;

    scr_pulse_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (i_clk_50m),
        .rst       (i_rst),
        .load      (tmr_load),
        .load_value(tmr_value),
        .expire    (tmr_expire)
    );

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_FWD;
            pulse_cnt_q <= '0;
            sig_fwd_q   <= 1'b0;
            sig_neg_q   <= 1'b0;
            fault_q     <= 1'b0;
            ack_q       <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pulse_cnt_q <= pulse_cnt_d;
            sig_fwd_q   <= sig_fwd_d;
            sig_neg_q   <= sig_neg_d;
            fault_q     <= fault_d;
            ack_q       <= ack_d;
            rej_q       <= rej_d;
        end
    end

    // BOD outranks forbid, which outranks timer expiry, in every non-fault state.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pulse_cnt_d = pulse_cnt_q;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bod_any) begin
                    state_d = ST_FAULT;
                end else if (fire_one && !i_signal_forbid && !fault_q) begin
                    accept      = 1'b1;
                    dir_d       = i_fire_negative ? DIR_NEG : DIR_FWD;
                    pulse_cnt_d = '0;
                    state_d     = ST_PULSE_HI;
                    tmr_load    = 1'b1;
                    tmr_value   = CNT_W'(PULSE_WIDTH);
                end
            end
            ST_PULSE_HI: begin
                if (bod_any) begin
                    state_d = ST_FAULT;
                end else if (i_signal_forbid) begin
                    state_d   = ST_DEAD;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(DEADTIME);
                end else if (tmr_expire) begin
                    pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
                    tmr_load    = 1'b1;
                    if (pulse_cnt_q + CNT_W'(1) == CNT_W'(PULSE_COUNT)) begin
                        state_d   = ST_DEAD;
                        tmr_value = CNT_W'(DEADTIME);
                    end else begin
                        state_d   = ST_PULSE_LO;
                        tmr_value = CNT_W'(PULSE_GAP);
                    end
                end
            end
            ST_PULSE_LO: begin
                if (bod_any) begin
                    state_d = ST_FAULT;
                end else if (i_signal_forbid) begin
                    state_d   = ST_DEAD;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(DEADTIME);
                end else if (tmr_expire) begin
                    state_d   = ST_PULSE_HI;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(PULSE_WIDTH);
                end
            end
            ST_DEAD: begin
                if (bod_any) begin
                    state_d = ST_FAULT;
                end else if (tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (i_fault_clr && !bod_any) begin
                    state_d   = ST_DEAD;
                    tmr_load  = 1'b1;
                    tmr_value = CNT_W'(DEADTIME);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        sig_fwd_d = (state_d == ST_PULSE_HI) && (dir_d == DIR_FWD);
        sig_neg_d = (state_d == ST_PULSE_HI) && (dir_d == DIR_NEG);
        fault_d   = (state_d == ST_FAULT);
        ack_d     = accept;
        rej_d     = fire_any && !accept;
    end

    assign o_signal_forward  = sig_fwd_q;
    assign o_signal_negative = sig_neg_q;
    assign o_busy            = (state_q != ST_IDLE);
    assign o_fire_ack        = ack_q;
    assign o_fire_reject     = rej_q;
    assign o_fault           = fault_q;

endmodule

// File: tb/tb_scr_trigger_gen.sv
// tb/tb_scr_trigger_gen.sv - directed self-checking bench for scr_trigger_gen
module tb_scr_trigger_gen;

    localparam int W = 4;
    localparam int G = 2;
    localparam int C = 3;
    localparam int D = 8;
    localparam int T = C * W + (C - 1) * G;

    typedef struct packed {
        logic fwd;
        logic neg;
        logic busy;
        logic ack;
        logic rej;
        logic fault;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fire_fwd = 1'b0;
    logic fire_neg = 1'b0;
    logic forbid = 1'b0;
    logic bod_fwd = 1'b0;
    logic bod_neg = 1'b0;
    logic fault_clr = 1'b0;
    logic sig_fwd, sig_neg, busy, ack, rej, fault;

    int   n_asserts = 0;
    int   n_fail = 0;
    obs_t exp_q[$];

    always #10 clk = ~clk;

    scr_trigger_gen #(
        .PULSE_WIDTH(W),
        .PULSE_GAP  (G),
        .PULSE_COUNT(C),
        .DEADTIME   (D),
        .CNT_W      (16)
    ) dut (
        .i_clk_50m        (clk),
        .i_rst            (rst),
        .i_fire_forward   (fire_fwd),
        .i_fire_negative  (fire_neg),
        .i_signal_forbid  (forbid),
        .i_forward_BOD    (bod_fwd),
        .i_negative_BOD   (bod_neg),
        .i_fault_clr      (fault_clr),
        .o_signal_forward (sig_fwd),
        .o_signal_negative(sig_neg),
        .o_busy           (busy),
        .o_fire_ack       (ack),
        .o_fire_reject    (rej),
        .o_fault          (fault)
    );

    // Expected outputs k cycles after a command accepted at edge N (k=1 is cycle N+1).
    function automatic obs_t exp_train(input logic neg_dir, input int k);
        obs_t e;
        logic pulse;
        e = '0;
        pulse = 1'b0;
        for (int p = 0; p < C; p++) begin
            if (k >= 1 + p * (W + G) && k <= p * (W + G) + W) pulse = 1'b1;
        end
        e.fwd  = pulse && !neg_dir;
        e.neg  = pulse && neg_dir;
        e.busy = (k >= 1) && (k <= T + D);
        e.ack  = (k == 1);
        return e;
    endfunction

    function automatic obs_t mk(input logic [5:0] bits);
        obs_t e;
        e = bits;
        return e;
    endfunction

    task automatic step(input obs_t e, input string tag);
        obs_t got;
        obs_t want;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {sig_fwd, sig_neg, busy, ack, rej, fault};
        want = exp_q.pop_front();
        n_asserts++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (fwd,neg,busy,ack,rej,fault)", tag, got, want);
        end
        n_asserts++;
        assert (!(sig_fwd === 1'b1 && sig_neg === 1'b1)) else begin
            n_fail++;
            $error("FAIL %s_exclusive observed fwd=%b neg=%b expected not both 1", tag, sig_fwd, sig_neg);
        end
    endtask

    initial begin
        obs_t e;

        // reset
        step(mk(6'b000000), "reset_0");
        step(mk(6'b000000), "reset_1");
        rst = 1'b0;
        for (int k = 0; k < 7; k++) step(mk(6'b000000), $sformatf("idle k=%0d", k));

        // single forward train
        fire_fwd = 1'b1;
        for (int k = 1; k <= T + D + 1; k++) begin
            step(exp_train(1'b0, k), $sformatf("fwd_train k=%0d", k));
            fire_fwd = 1'b0;
        end

        // both fire inputs together
        fire_fwd = 1'b1;
        fire_neg = 1'b1;
        step(mk(6'b000010), "both_reject");
        fire_fwd = 1'b0;
        fire_neg = 1'b0;
        step(mk(6'b000000), "both_after_0");
        step(mk(6'b000000), "both_after_1");

        // forbid with a command in IDLE
        forbid = 1'b1;
        fire_neg = 1'b1;
        step(mk(6'b000010), "forbid_idle_reject");
        forbid = 1'b0;
        fire_neg = 1'b0;
        step(mk(6'b000000), "forbid_idle_after");

        // negative train, forbid during the second pulse, command during DEAD
        fire_neg = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(exp_train(1'b1, k), $sformatf("neg_train k=%0d", k));
            fire_neg = 1'b0;
        end
        forbid = 1'b1;
        for (int k = 8; k <= 16; k++) begin
            e = mk(6'b000000);
            e.busy = (k <= 15);
            e.rej  = (k == 11);
            step(e, $sformatf("neg_abort k=%0d", k));
            forbid   = 1'b0;
            fire_fwd = (k == 10);
        end
        fire_fwd = 1'b0;

        // BOD mid-train, clear attempts, recovery
        fire_fwd = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(exp_train(1'b0, k), $sformatf("bod_train k=%0d", k));
            fire_fwd = 1'b0;
        end
        bod_fwd = 1'b1;
        step(mk(6'b001001), "bod_fault");
        fault_clr = 1'b1;
        fire_neg  = 1'b1;
        step(mk(6'b001011), "bod_clr_held");
        bod_fwd  = 1'b0;
        fire_neg = 1'b0;
        for (int k = 6; k <= 14; k++) begin
            e = mk(6'b000000);
            e.busy = (k <= 13);
            step(e, $sformatf("bod_dead k=%0d", k));
            fault_clr = 1'b0;
        end
        fire_neg = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(exp_train(1'b1, k), $sformatf("post_fault k=%0d", k));
            fire_neg = 1'b0;
        end

        // reset during PULSE_HI
        rst = 1'b1;
        step(mk(6'b000000), "rst_mid_0");
        rst = 1'b0;
        step(mk(6'b000000), "rst_mid_1");

        // BOD in IDLE then reset clears the fault
        bod_neg = 1'b1;
        step(mk(6'b001001), "bod_idle_fault");
        bod_neg = 1'b0;
        step(mk(6'b001001), "bod_idle_hold");
        rst = 1'b1;
        step(mk(6'b000000), "rst_clears_fault");
        rst = 1'b0;
        step(mk(6'b000000), "rst_clears_after");

        // back-to-back forward then negative
        fire_fwd = 1'b1;
        step(exp_train(1'b0, 1), "b2b_fwd k=1");
        fire_fwd = 1'b0;
        fire_neg = 1'b1;
        for (int k = 2; k <= T + D + 1; k++) begin
            e = exp_train(1'b0, k);
            e.rej = 1'b1;
            step(e, $sformatf("b2b_fwd k=%0d", k));
        end
        step(exp_train(1'b1, 1), "b2b_neg k=1");
        fire_neg = 1'b0;
        for (int k = 2; k <= T + D + 1; k++) step(exp_train(1'b1, k), $sformatf("b2b_neg k=%0d", k));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
